// File: rtl/wb_stage_regfile.sv
// rtl/wb_stage_regfile.sv - write-back stage with 32x32 register file, bypassed reads and retire counter
module wb_stage_regfile #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_rf_WB,
    input  logic [2:0]       wd_sel_WB,
    input  logic             stall_j_WB,
    input  logic [4:0]       wR_WB,
    input  logic [XLEN-1:0]  DMEM_rd_WB,
    input  logic [XLEN-1:0]  ALU_result_WB,
    input  logic [XLEN-1:0]  imm_WB,
    input  logic [XLEN-1:0]  PC_WB,
    input  logic [XLEN-1:0]  instruction_WB,
    input  logic [4:0]       rR1,
    input  logic [4:0]       rR2,
    output logic [XLEN-1:0]  rD1,
    output logic [XLEN-1:0]  rD2,
    output logic [XLEN-1:0]  wb_data,
    output logic             wb_we,
    output logic [CNT_W-1:0] retire_count
);

    logic [XLEN-1:0]  regs_q [NREG];
    logic [XLEN-1:0]  regs_d [NREG];
    logic [CNT_W-1:0] retire_q;
    logic [CNT_W-1:0] retire_d;

    logic [2:0]      funct3;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] load_data;
    logic            sel_valid;

    assign funct3 = instruction_WB[14:12];

    // Byte lanes are picked by the low address bits; halfwords ignore addr[0].
    always_comb begin
        ld_byte = DMEM_rd_WB[7:0];
        case (ALU_result_WB[1:0])
            2'd0:    ld_byte = DMEM_rd_WB[7:0];
            2'd1:    ld_byte = DMEM_rd_WB[15:8];
            2'd2:    ld_byte = DMEM_rd_WB[23:16];
            default: ld_byte = DMEM_rd_WB[31:24];
        endcase
        ld_half = ALU_result_WB[1] ? DMEM_rd_WB[31:16] : DMEM_rd_WB[15:0];
    end

    always_comb begin
        load_data = DMEM_rd_WB;
        case (funct3)
            3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b010:  load_data = DMEM_rd_WB;
            3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
            default: load_data = DMEM_rd_WB;
        endcase
    end

    always_comb begin
        wb_data   = '0;
        sel_valid = 1'b1;
        case (wd_sel_WB)
            3'b000:  wb_data = ALU_result_WB;
            3'b001:  wb_data = load_data;
            3'b010:  wb_data = PC_WB + XLEN'(4);
            3'b011:  wb_data = imm_WB;
            3'b100:  wb_data = PC_WB + imm_WB;
            default: sel_valid = 1'b0;
        endcase
    end

    assign wb_we = we_rf_WB & ~stall_j_WB & (wR_WB != 5'd0) & sel_valid;

    always_comb begin
        regs_d = regs_q;
        if (wb_we) begin
            regs_d[wR_WB] = wb_data;
        end
        regs_d[0] = '0;
    end

    // Retirement ignores wb_we so stores and branches are counted too.
    always_comb begin
        retire_d = retire_q;
        if (~stall_j_WB && (instruction_WB != '0)) begin
            retire_d = retire_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            retire_q <= '0;
        end else begin
            regs_q   <= regs_d;
            retire_q <= retire_d;
        end
    end

    // Same-cycle bypass hides the WB-to-ID hazard.
    always_comb begin
        rD1 = regs_q[rR1];
        if (rR1 == 5'd0) begin
            rD1 = '0;
        end else if (wb_we && (rR1 == wR_WB)) begin
            rD1 = wb_data;
        end
    end

    always_comb begin
        rD2 = regs_q[rR2];
        if (rR2 == 5'd0) begin
            rD2 = '0;
        end else if (wb_we && (rR2 == wR_WB)) begin
            rD2 = wb_data;
        end
    end

    assign retire_count = retire_q;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// tb/tb_wb_stage_regfile.sv - scoreboard bench for wb_stage_regfile
module tb_wb_stage_regfile;

    logic        clk;
    logic        rst_n;
    logic        we_rf_WB;
    logic [2:0]  wd_sel_WB;
    logic        stall_j_WB;
    logic [4:0]  wR_WB;
    logic [31:0] DMEM_rd_WB;
    logic [31:0] ALU_result_WB;
    logic [31:0] imm_WB;
    logic [31:0] PC_WB;
    logic [31:0] instruction_WB;
    logic [4:0]  rR1;
    logic [4:0]  rR2;
    logic [31:0] rD1;
    logic [31:0] rD2;
    logic [31:0] wb_data;
    logic        wb_we;
    logic [63:0] retire_count;

    typedef struct {
        string       name;
        logic [63:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_chk;
    int          n_fail;
    logic [63:0] exp_ret;

    wb_stage_regfile dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .we_rf_WB       (we_rf_WB),
        .wd_sel_WB      (wd_sel_WB),
        .stall_j_WB     (stall_j_WB),
        .wR_WB          (wR_WB),
        .DMEM_rd_WB     (DMEM_rd_WB),
        .ALU_result_WB  (ALU_result_WB),
        .imm_WB         (imm_WB),
        .PC_WB          (PC_WB),
        .instruction_WB (instruction_WB),
        .rR1            (rR1),
        .rR2            (rR2),
        .rD1            (rD1),
        .rD2            (rD2),
        .wb_data        (wb_data),
        .wb_we          (wb_we),
        .retire_count   (retire_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle();
        we_rf_WB       = 1'b0;
        wd_sel_WB      = 3'b000;
        stall_j_WB     = 1'b0;
        wR_WB          = 5'd0;
        DMEM_rd_WB     = '0;
        ALU_result_WB  = '0;
        imm_WB         = '0;
        PC_WB          = '0;
        instruction_WB = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        rR1 = 5'd0;
        rR2 = 5'd0;
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            rR1 = 5'(i);
            rR2 = 5'(31 - i);
            sb.push_back('{"reset_rd1", 64'd0});
            sb.push_back('{"reset_rd2", 64'd0});
            #1;
            e = sb.pop_front(); n_chk++;
            if ({32'd0, rD1} !== e.val) begin n_fail++; $display("FAIL %s[%0d]: got %h expected %h", e.name, i, rD1, e.val); end
            e = sb.pop_front(); n_chk++;
            if ({32'd0, rD2} !== e.val) begin n_fail++; $display("FAIL %s[%0d]: got %h expected %h", e.name, 31 - i, rD2, e.val); end
        end
        sb.push_back('{"reset_retire", 64'd0});
        sb.push_back('{"reset_wb_data", 64'd0});
        e = sb.pop_front(); n_chk++;
        if (retire_count !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, retire_count, e.val); end
        e = sb.pop_front(); n_chk++;
        if ({32'd0, wb_data} !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, wb_data, e.val); end
        rst_n   = 1'b1;
        exp_ret = '0;
    endtask

    task automatic test_alu_bypass();
        @(negedge clk);
        we_rf_WB = 1'b1; wd_sel_WB = 3'b000; wR_WB = 5'd5;
        ALU_result_WB = 32'h1234_5678; instruction_WB = 32'h0000_0013;
        rR1 = 5'd5; rR2 = 5'd5;
        sb.push_back('{"bypass_rd1", 64'h1234_5678});
        sb.push_back('{"bypass_rd2", 64'h1234_5678});
        sb.push_back('{"bypass_we", 64'd1});
        exp_ret++;
        #1;
        e = sb.pop_front(); n_chk++;
        if ({32'd0, rD1} !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rD1, e.val); end
        e = sb.pop_front(); n_chk++;
        if ({32'd0, rD2} !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rD2, e.val); end
        e = sb.pop_front(); n_chk++;
        if ({63'd0, wb_we} !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, wb_we, e.val); end
        @(negedge clk);
        idle();
        sb.push_back('{"array_rd1", 64'h1234_5678});
        sb.push_back('{"retire_after_alu", exp_ret});
        #1;
        e = sb.pop_front(); n_chk++;
        if ({32'd0, rD1} !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rD1, e.val); end
        e = sb.pop_front(); n_chk++;
        if (retire_count !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, retire_count, e.val); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [1:0]  addr [5] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1};
        logic [31:0] expv [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            we_rf_WB = 1'b1; wd_sel_WB = 3'b001; wR_WB = 5'd10;
            DMEM_rd_WB = 32'h80FF_7F01; ALU_result_WB = {28'h0000_100, 2'b00, addr[i]};
            instruction_WB = {17'd0, f3[i], 5'd10, 7'b0000011};
            rR1 = 5'd10; rR2 = 5'd0;
            sb.push_back('{"load_wb_data", {32'd0, expv[i]}});
            exp_ret++;
            #1;
            e = sb.pop_front(); n_chk++;
            if ({32'd0, wb_data} !== e.val) begin n_fail++; $display("FAIL %s[%0d]: got %h expected %h", e.name, i, wb_data, e.val); end
        end
        @(negedge clk);
        idle();
        sb.push_back('{"load_array_r10", 64'h80FF_7F01});
        #1;
        e = sb.pop_front(); n_chk++;
        if ({32'd0, rD1} !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rD1, e.val); end
    endtask

    task automatic test_x0_and_stall();
        @(negedge clk);
        we_rf_WB = 1'b1; wd_sel_WB = 3'b000; wR_WB = 5'd0;
        ALU_result_WB = 32'hDEAD_BEEF; instruction_WB = 32'h0000_0013;
        rR1 = 5'd0; rR2 = 5'd0;
        sb.push_back('{"x0_we", 64'd0});
        sb.push_back('{"x0_rd1", 64'd0});
        exp_ret++;
        #1;
        e = sb.pop_front(); n_chk++;
        if ({63'd0, wb_we} !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, wb_we, e.val); end
        e = sb.pop_front(); n_chk++;
        if ({32'd0, rD1} !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rD1, e.val); end
        @(negedge clk);
        wR_WB = 5'd7; ALU_result_WB = 32'h0000_1111;
        exp_ret++;
        @(negedge clk);
        stall_j_WB = 1'b1; ALU_result_WB = 32'h0000_7777; rR1 = 5'd7;
        sb.push_back('{"stall_we", 64'd0});
        sb.push_back('{"stall_no_bypass", 64'h0000_1111});
        #1;
        e = sb.pop_front(); n_chk++;
        if ({63'd0, wb_we} !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, wb_we, e.val); end
        e = sb.pop_front(); n_chk++;
        if ({32'd0, rD1} !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rD1, e.val); end
        @(negedge clk);
        idle();
        sb.push_back('{"stall_reg7", 64'h0000_1111});
        sb.push_back('{"stall_retire", exp_ret});
        #1;
        e = sb.pop_front(); n_chk++;
        if ({32'd0, rD1} !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rD1, e.val); end
        e = sb.pop_front(); n_chk++;
        if (retire_count !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, retire_count, e.val); end
    endtask

    task automatic test_pc_imm();
        logic [2:0]  sel  [5] = '{3'b010, 3'b010, 3'b100, 3'b011, 3'b110};
        logic [31:0] pc   [5] = '{32'hFFFF_FFFC, 32'h0000_1000, 32'h0000_0100, 32'h0, 32'h0000_2000};
        logic [31:0] imm  [5] = '{32'h0, 32'h0, 32'hFFFF_FFF0, 32'h0000_0ABC, 32'h0000_0040};
        logic [31:0] expd [5] = '{32'h0, 32'h0000_1004, 32'h0000_00F0, 32'h0000_0ABC, 32'h0};
        logic        expw [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            we_rf_WB = 1'b1; wd_sel_WB = sel[i]; wR_WB = 5'(11 + i);
            PC_WB = pc[i]; imm_WB = imm[i]; instruction_WB = 32'h0000_0017;
            rR1 = 5'(11 + i); rR2 = 5'd0;
            sb.push_back('{"sel_wb_data", {32'd0, expd[i]}});
            sb.push_back('{"sel_wb_we", {63'd0, expw[i]}});
            exp_ret++;
            #1;
            e = sb.pop_front(); n_chk++;
            if ({32'd0, wb_data} !== e.val) begin n_fail++; $display("FAIL %s[%0d]: got %h expected %h", e.name, i, wb_data, e.val); end
            e = sb.pop_front(); n_chk++;
            if ({63'd0, wb_we} !== e.val) begin n_fail++; $display("FAIL %s[%0d]: got %h expected %h", e.name, i, wb_we, e.val); end
        end
        @(negedge clk);
        idle();
        rR1 = 5'd12; rR2 = 5'd15;
        sb.push_back('{"pc4_array_r12", 64'h0000_1004});
        sb.push_back('{"reserved_r15", 64'd0});
        #1;
        e = sb.pop_front(); n_chk++;
        if ({32'd0, rD1} !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rD1, e.val); end
        e = sb.pop_front(); n_chk++;
        if ({32'd0, rD2} !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rD2, e.val); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [5];
        vals[0] = '0;
        for (int i = 1; i <= 4; i++) begin
            vals[i] = $urandom;
            @(negedge clk);
            we_rf_WB = 1'b1; wd_sel_WB = 3'b000; wR_WB = 5'(20 + i);
            ALU_result_WB = vals[i]; instruction_WB = 32'h0000_0033;
            rR1 = 5'(20 + i);
            rR2 = (i == 1) ? 5'd0 : 5'(19 + i);
            sb.push_back('{"b2b_bypass", {32'd0, vals[i]}});
            sb.push_back('{"b2b_prev", {32'd0, vals[i-1]}});
            exp_ret++;
            #1;
            e = sb.pop_front(); n_chk++;
            if ({32'd0, rD1} !== e.val) begin n_fail++; $display("FAIL %s[%0d]: got %h expected %h", e.name, i, rD1, e.val); end
            e = sb.pop_front(); n_chk++;
            if ({32'd0, rD2} !== e.val) begin n_fail++; $display("FAIL %s[%0d]: got %h expected %h", e.name, i, rD2, e.val); end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        we_rf_WB = 1'b1; wd_sel_WB = 3'b000; wR_WB = 5'd3;
        ALU_result_WB = 32'h0000_00A5; instruction_WB = 32'h0000_0013;
        exp_ret++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            we_rf_WB = 1'b0; instruction_WB = 32'h0000_0063 + 32'(i << 7);
            exp_ret++;
        end
        @(negedge clk);
        idle();
        rR1 = 5'd3; rR2 = 5'd0;
        sb.push_back('{"pre_reset_r3", 64'h0000_00A5});
        sb.push_back('{"pre_reset_retire", exp_ret});
        #1;
        e = sb.pop_front(); n_chk++;
        if ({32'd0, rD1} !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rD1, e.val); end
        e = sb.pop_front(); n_chk++;
        if (retire_count !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, retire_count, e.val); end
        #1;
        rst_n = 1'b0;
        sb.push_back('{"mid_reset_r3", 64'd0});
        sb.push_back('{"mid_reset_retire", 64'd0});
        #1;
        e = sb.pop_front(); n_chk++;
        if ({32'd0, rD1} !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, rD1, e.val); end
        e = sb.pop_front(); n_chk++;
        if (retire_count !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, retire_count, e.val); end
        @(negedge clk);
        rst_n   = 1'b1;
        exp_ret = '0;
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        exp_ret = '0;
        test_reset();
        test_alu_bypass();
        test_loads();
        test_x0_and_stall();
        test_pc_imm();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage_regfile.md
Name: wb_stage_regfile

Overview:
- Write-back stage of the five-stage pipeline. It consumes the registered outputs of the MEM/WB pipeline register.
- Selects and formats the write-back value, writes the 32x32 architectural register file, and serves the two ID-stage read ports with same-cycle write bypass.
- Exports the effective write-back value and enable for EX-stage forwarding.
- Maintains a 64-bit retired-instruction counter.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, number of architectural registers; register 0 is hardwired to zero.
- CNT_W, 64, retire counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- we_rf_WB  in  1  register-file write request from MEM/WB.
- wd_sel_WB  in  3  write-data source select.
- stall_j_WB  in  1  bubble flag: the instruction in WB is a jump-induced bubble.
- wR_WB  in  5  destination register index.
- DMEM_rd_WB  in  32  raw data-memory read word.
- ALU_result_WB  in  32  ALU result; also the load byte address.
- imm_WB  in  32  extended immediate.
- PC_WB  in  32  instruction PC.
- instruction_WB  in  32  instruction word; funct3 = bits [14:12].
- rR1  in  5  ID read index 1.
- rR2  in  5  ID read index 2.
- rD1  out  32  read data 1.
- rD2  out  32  read data 2.
- wb_data  out  32  formatted write-back value (combinational).
- wb_we  out  1  effective write enable (combinational).
- retire_count  out  64  count of retired instructions.

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk. While reset is asserted:
  - all NREG registers clear to 0;
  - retire_count clears to 0;
  - rD1, rD2 and wb_data read 0, because all inputs from MEM/WB are 0 during reset.
- Source select wd_sel_WB:
  - 000 selects ALU_result_WB.
  - 001 selects formatted load data.
  - 010 selects PC_WB+4, wrapping mod 2^32.
  - 011 selects imm_WB.
  - 100 selects PC_WB+imm_WB (auipc), wrapping mod 2^32.
  - 101..111 are reserved: wb_data=0 and wb_we=0.
- Load formatting uses funct3 and ALU_result_WB[1:0]:
  - LB (000): byte at addr[1:0], sign-extended.
  - LH (001): halfword at addr[1], sign-extended; addr[0] is ignored.
  - LW (010): full word; addr[1:0] are ignored.
  - LBU (100): byte at addr[1:0], zero-extended.
  - LHU (101): halfword at addr[1], zero-extended.
  - Any other funct3: raw DMEM_rd_WB.
- Effective enable: wb_we = we_rf_WB & ~stall_j_WB & (wR_WB!=0) & (wd_sel_WB not reserved).
- Write: on posedge clk, if wb_we, then reg[wR_WB] <= wb_data. Register 0 is never written.
- Reads are combinational. For each port n: if rRn==0, rDn=0; else if wb_we and rRn==wR_WB, rDn=wb_data (bypass); else rDn=reg[rRn].
  - The bypass removes the WB-to-ID hazard with zero added latency.
  - Both ports may bypass simultaneously when rR1==rR2==wR_WB.
- Retire: on posedge clk, retire_count increments by 1 when ~stall_j_WB & (instruction_WB!=0).
  - This is independent of wb_we, so stores and branches also count.
  - The bubble/reset encoding instruction_WB=0 never counts.
  - The counter wraps from 2^64-1 to 0.
- Reset mid-operation clears the register file and counter immediately. Any write scheduled for the next edge is lost.
- Write latency is 1 cycle: the value is visible through the array on the cycle after the write edge, and through the bypass on the same cycle.

Test Plan:
- Reset, then read every index on rR1/rR2 -> all 0; retire_count=0.
- wd_sel=000, ALU=0x1234_5678, wR=5, we=1, rR1=5 in the same cycle -> rD1=0x1234_5678 via bypass; next cycle still 0x1234_5678 from the array; retire_count=1.
- wd_sel=001, DMEM_rd=0x80FF_7F01, then funct3/addr = LB/3, LBU/3, LH/2, LHU/2, LW/1 -> 0xFFFF_FF80, 0x0000_0080, 0xFFFF_80FF, 0x0000_80FF, 0x80FF_7F01.
- wR=0, we=1, ALU=0xDEAD_BEEF -> wb_we=0; rD1 for rR1=0 reads 0. stall_j=1 with wR=7 -> reg7 unchanged and retire_count unchanged.
- wd_sel=010, PC=0xFFFF_FFFC -> wb_data=0. wd_sel=100, PC=0x100, imm=0xFFFF_FFF0 -> wb_data=0xF0. wd_sel=110 -> wb_we=0, no write.
- Write reg3=0xA5 and 10 non-bubble instructions, assert rst_n=0 mid-cycle -> reg3 and retire_count read 0 immediately, before the next clock edge.
